// File: rtl/ls_station.sv
// ls_station: load/store reservation station with a per-register in-flight
// scoreboard. Issue allocates entries into a load or store queue. Completions
// on the databus retire busy entries whose tag and address match. A saturating
// counter per architectural register lets issue stall on hazards.
module ls_station #(
  parameter int DEPTH  = 4,
  parameter int NREG   = 32,
  parameter int REG_W  = 5,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [31:0]                  alloc_op,
  input  logic [ADDR_W-1:0]            alloc_addr,
  input  logic [REG_W-1:0]             alloc_reg,
  input  logic [REG_W-1:0]             alloc_reg2,
  input  logic [63:0]                  in_databus,
  input  logic [REG_W-1:0]             chk_reg,
  output logic                         chk_busy,
  output logic                         rs_lok,
  output logic                         rs_sok,
  output logic                         rs_free,
  output logic [$clog2(DEPTH+1)-1:0]   load_count,
  output logic [$clog2(DEPTH+1)-1:0]   store_count,
  output logic                         err_underflow
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int CMAX = (1 << CNT_W) - 1;

  localparam logic [31:0] OP_LOAD   = 32'd9;
  localparam logic [31:0] OP_STORE  = 32'd10;
  localparam logic [15:0] TAG_LOAD  = 16'd1;
  localparam logic [15:0] TAG_STORE = 16'd2;

  // Load queue state
  logic [DEPTH-1:0]  lBusy_q;
  logic [DEPTH-1:0]  lBusy_d;
  logic [ADDR_W-1:0] lAddr_q [DEPTH];
  logic [REG_W-1:0]  lReg_q  [DEPTH];
  logic [REG_W-1:0]  lReg2_q [DEPTH];

  // Store queue state
  logic [DEPTH-1:0]  sBusy_q;
  logic [DEPTH-1:0]  sBusy_d;
  logic [ADDR_W-1:0] sAddr_q [DEPTH];
  logic [REG_W-1:0]  sReg_q  [DEPTH];
  logic [REG_W-1:0]  sReg2_q [DEPTH];

  // Register scoreboard
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic              err_q;
  logic              err_d;

  // Combinational helpers
  logic              isLoad;
  logic              isStore;
  logic              cntOvf;
  logic              fire;
  logic [1:0]        regInc [NREG];
  logic [DEPTH-1:0]  lAlloc;
  logic [DEPTH-1:0]  sAlloc;
  logic [DEPTH-1:0]  lClr;
  logic [DEPTH-1:0]  sClr;
  logic              underflowHit;
  logic [15:0]       busTag;
  logic [ADDR_W-1:0] busAddr;
  logic [47:ADDR_W]  unusedBus;

  assign busTag    = in_databus[63:48];
  assign busAddr   = in_databus[ADDR_W-1:0];
  assign unusedBus = in_databus[47:ADDR_W];

  // One-hot of the lowest-index free slot, zero when the queue is full.
  function automatic logic [DEPTH-1:0] firstFree(input logic [DEPTH-1:0] busy);
    logic found;
    firstFree = '0;
    found     = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (!found && !busy[j]) begin
        firstFree[j] = 1'b1;
        found        = 1'b1;
      end
    end
  endfunction

  function automatic logic [CW-1:0] popCount(input logic [DEPTH-1:0] v);
    popCount = '0;
    for (int j = 0; j < DEPTH; j++) begin
      popCount = popCount + CW'(v[j]);
    end
  endfunction

  // Per-register increment an allocation would contribute; register 0 is never tracked.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regInc[i] = 2'd0;
      if (i != 0) begin
        regInc[i] = 2'(alloc_reg == REG_W'(i)) + 2'(alloc_reg2 == REG_W'(i));
      end
    end
  end

  // Refuse an allocation that would push any counter past its maximum.
  always_comb begin
    cntOvf = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (regInc[i] == 2'd2 && cnt_q[i] >= CNT_W'(CMAX - 1)) begin
        cntOvf = 1'b1;
      end
      if (regInc[i] == 2'd1 && cnt_q[i] == CNT_W'(CMAX)) begin
        cntOvf = 1'b1;
      end
    end
  end

  // Handshake decode: ready depends only on the op, its registers and registered state.
  always_comb begin
    isLoad      = (alloc_op == OP_LOAD);
    isStore     = (alloc_op == OP_STORE);
    alloc_ready = !(isLoad && (&lBusy_q)) && !(isStore && (&sBusy_q)) && !cntOvf;
    fire        = alloc_valid && alloc_ready;
  end

  // Placement uses pre-update busy bits, so a slot freed this cycle is reused next cycle.
  always_comb begin
    lAlloc = (fire && isLoad)  ? firstFree(lBusy_q) : '0;
    sAlloc = (fire && isStore) ? firstFree(sBusy_q) : '0;
  end

  // Completions only see entries that were busy before this edge.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      lClr[j] = (busTag == TAG_LOAD)  && lBusy_q[j] && (lAddr_q[j] == busAddr);
      sClr[j] = (busTag == TAG_STORE) && sBusy_q[j] && (sAddr_q[j] == busAddr);
    end
    lBusy_d = (lBusy_q & ~lClr) | lAlloc;
    sBusy_d = (sBusy_q & ~sClr) | sAlloc;
  end

  // Net per-register delta for the cycle, clamped at 0 with the underflow flag raised.
  always_comb begin
    int net;
    underflowHit = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      net = int'(cnt_q[i]);
      if (fire) begin
        net = net + int'(regInc[i]);
      end
      for (int j = 0; j < DEPTH; j++) begin
        if (lClr[j] && lReg_q[j]  == REG_W'(i)) net = net - 1;
        if (lClr[j] && lReg2_q[j] == REG_W'(i)) net = net - 1;
        if (sClr[j] && sReg_q[j]  == REG_W'(i)) net = net - 1;
        if (sClr[j] && sReg2_q[j] == REG_W'(i)) net = net - 1;
      end
      if (i == 0) begin
        net = 0;
      end
      if (net < 0) begin
        net          = 0;
        underflowHit = 1'b1;
      end
      if (net > CMAX) begin
        net = CMAX;
      end
      cnt_d[i] = CNT_W'(net);
    end
    err_d = err_q | underflowHit;
  end

  // State update; reset wins over any completion or allocation in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      lBusy_q <= '0;
      sBusy_q <= '0;
      err_q   <= 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        lAddr_q[j] <= '0;
        lReg_q[j]  <= '0;
        lReg2_q[j] <= '0;
        sAddr_q[j] <= '0;
        sReg_q[j]  <= '0;
        sReg2_q[j] <= '0;
      end
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      lBusy_q <= lBusy_d;
      sBusy_q <= sBusy_d;
      err_q   <= err_d;
      for (int j = 0; j < DEPTH; j++) begin
        if (lAlloc[j]) begin
          lAddr_q[j] <= alloc_addr;
          lReg_q[j]  <= alloc_reg;
          lReg2_q[j] <= alloc_reg2;
        end
        if (sAlloc[j]) begin
          sAddr_q[j] <= alloc_addr;
          sReg_q[j]  <= alloc_reg;
          sReg2_q[j] <= alloc_reg2;
        end
      end
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Status outputs decoded purely from registered state (plus the hazard query index).
  always_comb begin
    rs_lok        = ~(&lBusy_q);
    rs_sok        = ~(&sBusy_q);
    rs_free       = ~(|lBusy_q) && ~(|sBusy_q);
    load_count    = popCount(lBusy_q);
    store_count   = popCount(sBusy_q);
    err_underflow = err_q;
    chk_busy      = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (chk_reg == REG_W'(i) && cnt_q[i] != '0) begin
        chk_busy = 1'b1;
      end
    end
  end

endmodule
